// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller signal bundle; perf ports exist only with PIPE_HAZARD_CTRL_PERF_EN
interface pipe_hazard_ctrl_if
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  #(parameter int CNT_W = 16)
`endif
;
  logic       dec_valid;
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic       dec_uses_rs1;
  logic       dec_uses_rs2;
  logic       exe_valid;
  logic       exe_is_load;
  logic [4:0] exe_rd;
  logic       exe_rd_we;
  logic       exe_redirect;
  logic       exe_muldiv;
  logic       muldiv_done;
  logic       mem_req;
  logic       mem_ack;
  logic       stall_if;
  logic       stall_id;
  logic       stall_exe;
  logic       stall_mem;
  logic       flush_id;
  logic       flush_exe;
  logic [1:0] state;
  logic       muldiv_err;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] perf_stall_cnt;
  logic [CNT_W-1:0] perf_flush_cnt;
`endif

  // master is the hazard controller, slave is the core pipeline
  modport master (
    input  dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
    input  exe_valid, exe_is_load, exe_rd, exe_rd_we, exe_redirect, exe_muldiv,
    input  muldiv_done, mem_req, mem_ack,
    output stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    output perf_stall_cnt, perf_flush_cnt,
`endif
    output state, muldiv_err
  );

  modport slave (
    output dec_valid, dec_rs1, dec_rs2, dec_uses_rs1, dec_uses_rs2,
    output exe_valid, exe_is_load, exe_rd, exe_rd_we, exe_redirect, exe_muldiv,
    output muldiv_done, mem_req, mem_ack,
    input  stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe,
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    input  perf_stall_cnt, perf_flush_cnt,
`endif
    input  state, muldiv_err
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush controller; PIPE_HAZARD_CTRL_PERF_EN adds perf counters
module pipe_hazard_ctrl #(
  parameter int MULDIV_TIMEOUT = 40
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  , parameter int CNT_W = 16
`endif
) (
  input logic                 clk,
  input logic                 rst,
  pipe_hazard_ctrl_if.master  bus
);
  localparam int TW = $clog2(MULDIV_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    MULDIV_WAIT = 2'd1,
    MEM_WAIT    = 2'd2
  } state_t;

  state_t          st;
  logic [TW-1:0]   cnt;
  logic            err;

  logic mem_pend, md_start, load_use, md_timeout, md_hold;
  logic s_if, s_id, s_exe, s_mem, f_id, f_exe;

  assign mem_pend   = bus.mem_req & ~bus.mem_ack;
  assign md_start   = bus.exe_valid & bus.exe_muldiv & ~bus.muldiv_done;
  assign load_use   = bus.exe_valid & bus.exe_is_load & bus.exe_rd_we & (bus.exe_rd != 5'd0) &
                      bus.dec_valid &
                      ((bus.dec_uses_rs1 & (bus.dec_rs1 == bus.exe_rd)) |
                       (bus.dec_uses_rs2 & (bus.dec_rs2 == bus.exe_rd)));
  assign md_timeout = (st == MULDIV_WAIT) & ~bus.muldiv_done & (cnt == TW'(MULDIV_TIMEOUT - 1));
  assign md_hold    = ~bus.muldiv_done & ~md_timeout;

  always_comb begin
    s_if  = 1'b0;
    s_id  = 1'b0;
    s_exe = 1'b0;
    s_mem = 1'b0;
    f_id  = 1'b0;
    f_exe = 1'b0;
    if (!rst) begin
      case (st)
        RUN: begin
          if (mem_pend) begin
            {s_if, s_id, s_exe, s_mem} = 4'b1111;
          end else if (md_start) begin
            {s_if, s_id, s_exe} = 3'b111;
          end else if (bus.exe_redirect) begin
            // redirect kills both younger slots, which also covers a dependent load-use
            f_id  = 1'b1;
            f_exe = 1'b1;
          end else if (load_use) begin
            s_if  = 1'b1;
            s_id  = 1'b1;
            f_exe = 1'b1;
          end
        end
        MULDIV_WAIT: begin
          // a frozen MEM stage must also hold everything upstream of it
          s_if  = md_hold | mem_pend;
          s_id  = md_hold | mem_pend;
          s_exe = md_hold | mem_pend;
          s_mem = mem_pend;
        end
        MEM_WAIT: begin
          {s_if, s_id, s_exe, s_mem} = {4{~bus.mem_ack}};
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st  <= RUN;
      cnt <= '0;
      err <= 1'b0;
    end else begin
      case (st)
        RUN: begin
          if (mem_pend) begin
            st <= MEM_WAIT;
          end else if (md_start) begin
            st  <= MULDIV_WAIT;
            cnt <= '0;
          end
        end
        MULDIV_WAIT: begin
          cnt <= cnt + 1'b1;
          if (bus.muldiv_done) begin
            st <= RUN;
          end else if (md_timeout) begin
            err <= 1'b1;
            st  <= RUN;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_ack) st <= RUN;
        end
        default: st <= RUN;
      endcase
    end
  end

  assign bus.stall_if   = s_if;
  assign bus.stall_id   = s_id;
  assign bus.stall_exe  = s_exe;
  assign bus.stall_mem  = s_mem;
  assign bus.flush_id   = f_id;
  assign bus.flush_exe  = f_exe;
  assign bus.state      = st;
  assign bus.muldiv_err = err;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (s_if && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (f_id && !(&flush_cnt)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign bus.perf_stall_cnt = stall_cnt;
  assign bus.perf_flush_cnt = flush_cnt;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed and random checks of pipe_hazard_ctrl against a cycle model
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 40;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // model: mode 0 run, 1 waiting on muldiv, 2 waiting on memory
  int   m_mode   = 0;
  int   m_waited = 0;
  logic m_err    = 1'b0;

  pipe_hazard_ctrl_if hif ();

  pipe_hazard_ctrl #(.MULDIV_TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (hif)
  );

  always #5 clk = ~clk;

  logic [5:0] outs;
  assign outs = {hif.stall_if, hif.stall_id, hif.stall_exe, hif.stall_mem, hif.flush_id, hif.flush_exe};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic lu_hit();
    if (!(hif.exe_valid && hif.exe_is_load && hif.exe_rd_we && hif.dec_valid)) return 1'b0;
    if (hif.exe_rd == 0) return 1'b0;
    return (hif.dec_uses_rs1 && hif.dec_rs1 == hif.exe_rd) ||
           (hif.dec_uses_rs2 && hif.dec_rs2 == hif.exe_rd);
  endfunction

  function automatic logic [5:0] model_out();
    logic pend = hif.mem_req && !hif.mem_ack;
    logic hold;
    if (rst) return 6'b000000;
    if (m_mode == 2) return hif.mem_ack ? 6'b000000 : 6'b111100;
    if (m_mode == 1) begin
      hold = !hif.muldiv_done && (m_waited != TIMEOUT);
      return {{3{hold | pend}}, pend, 2'b00};
    end
    if (pend) return 6'b111100;
    if (hif.exe_valid && hif.exe_muldiv && !hif.muldiv_done) return 6'b111000;
    if (hif.exe_redirect) return 6'b000011;
    if (lu_hit()) return 6'b110001;
    return 6'b000000;
  endfunction

  task automatic model_advance();
    if (rst) begin
      m_mode = 0; m_waited = 0; m_err = 1'b0;
    end else if (m_mode == 0) begin
      if (hif.mem_req && !hif.mem_ack) m_mode = 2;
      else if (hif.exe_valid && hif.exe_muldiv && !hif.muldiv_done) begin
        m_mode = 1; m_waited = 1;
      end
    end else if (m_mode == 1) begin
      if (hif.muldiv_done) m_mode = 0;
      else if (m_waited == TIMEOUT) begin m_err = 1'b1; m_mode = 0; end
      else m_waited++;
    end else begin
      if (hif.mem_ack) m_mode = 0;
    end
  endtask

  task automatic idle();
    hif.dec_valid = 0; hif.dec_rs1 = 0; hif.dec_rs2 = 0; hif.dec_uses_rs1 = 0; hif.dec_uses_rs2 = 0;
    hif.exe_valid = 0; hif.exe_is_load = 0; hif.exe_rd = 0; hif.exe_rd_we = 0;
    hif.exe_redirect = 0; hif.exe_muldiv = 0; hif.muldiv_done = 0; hif.mem_req = 0; hif.mem_ack = 0;
  endtask

  task automatic step(input string tag);
    #1;
    chk({tag, ":out"}, 32'(outs), 32'(model_out()));
    chk({tag, ":state"}, 32'(hif.state), 32'(m_mode));
    chk({tag, ":err"}, 32'(hif.muldiv_err), 32'(m_err));
    model_advance();
    @(negedge clk);
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    hif.exe_valid = 1; hif.exe_is_load = 1; hif.exe_rd_we = 1; hif.exe_rd = rd;
    hif.dec_valid = 1; hif.dec_uses_rs1 = 1; hif.dec_rs1 = 5'd5; hif.dec_rs2 = 5'd7; hif.dec_uses_rs2 = 1;
  endtask

  initial begin
    idle();
    hif.mem_req = 1;
    #2 rst = 1'b1;
    @(negedge clk); @(negedge clk);
    #1;
    chk("reset_out", 32'(outs), 0);
    chk("reset_state", 32'(hif.state), 0);
    chk("reset_err", 32'(hif.muldiv_err), 0);
    model_advance();
    idle();
    @(negedge clk);
    rst = 1'b0;

    // LW x5 then ADD x6,x5,x7: one bubble
    set_load_use(5'd5);
    #1 chk("lu_hit", 32'(outs), 32'(6'b110001));
    step("lu_hit");
    hif.exe_valid = 0;
    #1 chk("lu_after", 32'(outs), 0);
    step("lu_after");

    // LW x0 never interlocks
    set_load_use(5'd0);
    hif.dec_rs1 = 5'd0;
    #1 chk("lu_x0", 32'(outs), 0);
    step("lu_x0");

    // redirect beats load-use
    set_load_use(5'd5);
    hif.exe_redirect = 1;
    #1 chk("redir_lu", 32'(outs), 32'(6'b000011));
    step("redir_lu");
    chk("redir_state", 32'(hif.state), 0);
    idle();

    // MUL with done in the fifth wait cycle
    hif.exe_valid = 1; hif.exe_muldiv = 1;
    step("mul_start");
    for (int i = 0; i < 5; i++) begin
      if (i == 4) hif.muldiv_done = 1;
      #1 chk("mul_wait_state", 32'(hif.state), 1);
      chk("mul_wait_out", 32'(outs), (i == 4) ? 0 : 32'(6'b111000));
      step("mul_wait");
    end
    idle();
    chk("mul_done_state", 32'(hif.state), 0);
    step("mul_idle");

    // MUL that never completes
    hif.exe_valid = 1; hif.exe_muldiv = 1;
    step("to_start");
    for (int i = 0; i < TIMEOUT; i++) step("to_wait");
    idle();
    chk("to_err", 32'(hif.muldiv_err), 1);
    chk("to_state", 32'(hif.state), 0);
    for (int i = 0; i < 3; i++) step("to_sticky");

    // memory wait interrupted by reset
    hif.mem_req = 1;
    step("mem_req");
    step("mem_wait1");
    #1 chk("mem_wait2", 32'(outs), 32'(6'b111100));
    rst = 1'b1;
    #1;
    chk("mem_rst_out", 32'(outs), 0);
    chk("mem_rst_state", 32'(hif.state), 0);
    chk("mem_rst_err", 32'(hif.muldiv_err), 0);
    model_advance();
    @(negedge clk);
    rst = 1'b0;
    idle();
    step("post_rst");

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      hif.dec_valid    = ($urandom_range(0, 3) != 0);
      hif.dec_rs1      = 5'($urandom_range(0, 3));
      hif.dec_rs2      = 5'($urandom_range(0, 3));
      hif.dec_uses_rs1 = 1'($urandom);
      hif.dec_uses_rs2 = 1'($urandom);
      hif.exe_valid    = ($urandom_range(0, 3) != 0);
      hif.exe_is_load  = 1'($urandom);
      hif.exe_rd       = 5'($urandom_range(0, 3));
      hif.exe_rd_we    = ($urandom_range(0, 3) != 0);
      hif.exe_redirect = ($urandom_range(0, 5) == 0);
      hif.exe_muldiv   = ($urandom_range(0, 7) == 0);
      hif.muldiv_done  = ($urandom_range(0, 2) == 0);
      hif.mem_req      = ($urandom_range(0, 5) == 0);
      hif.mem_ack      = 1'($urandom);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
